pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states,
// ALU-stage memory-op codes and ALU opcode constants.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LDST_NONE  = 2'b00,
        LDST_LOAD  = 2'b01,
        LDST_STORE = 2'b10,
        LDST_RSVD  = 2'b11
    } ldst_e;

    localparam logic [3:0] ALU_OP_ADD = 4'h0;
    localparam logic [3:0] ALU_OP_SUB = 4'h1;
    localparam logic [3:0] ALU_OP_AND = 4'h2;
    localparam logic [3:0] ALU_OP_OR  = 4'h3;
    localparam logic [3:0] ALU_OP_XOR = 4'h4;
    localparam logic [3:0] ALU_OP_SLT = 4'h5;

    localparam int WAIT_CNT_W  = 8;
    localparam int FLUSH_CNT_W = 3;
    localparam int STALL_CNT_W = 16;

    // The reserved code behaves as no memory access.
    function automatic logic is_mem_op(input logic [1:0] ldst);
        return (ldst == LDST_LOAD) || (ldst == LDST_STORE);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in the ALU stage whose destination
// matches a source register actually read by the decode-stage instruction.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [2:0] dec_srcA_addr,
    input  logic [2:0] dec_srcB_addr,
    input  logic       dec_useA,
    input  logic       dec_useB,
    input  logic [2:0] alu_destReg_addr,
    input  logic       alu_we,
    input  logic [1:0] alu_ldSt_enable,
    output logic       load_use
);

    logic match_a;
    logic match_b;

    assign match_a  = dec_useA && (dec_srcA_addr == alu_destReg_addr);
    assign match_b  = dec_useB && (dec_srcB_addr == alu_destReg_addr);
    assign load_use = (alu_ldSt_enable == LDST_LOAD) && alu_we && (match_a || match_b);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: Mealy FSM arbitrating memory waits,
// taken-branch flushes and load-use stalls, plus timeout and stall statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  dec_srcA_addr,
    input  logic [2:0]  dec_srcB_addr,
    input  logic        dec_useA,
    input  logic        dec_useB,
    input  logic [2:0]  alu_destReg_addr,
    input  logic        alu_we,
    input  logic [1:0]  alu_ldSt_enable,
    input  logic        mem_busy,
    input  logic        branch_taken,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_alu,
    output logic        enable_mem,
    output logic        bubble_alu,
    output logic        flush_decode,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam logic [WAIT_CNT_W-1:0]  MAX_WAIT_C   = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT_C = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [WAIT_CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                     timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0]   stall_q, stall_d;

    logic       load_use;
    logic       mem_event;
    logic [3:0] en;

    hazard_detect u_hazard_detect (
        .dec_srcA_addr    (dec_srcA_addr),
        .dec_srcB_addr    (dec_srcB_addr),
        .dec_useA         (dec_useA),
        .dec_useB         (dec_useB),
        .alu_destReg_addr (alu_destReg_addr),
        .alu_we           (alu_we),
        .alu_ldSt_enable  (alu_ldSt_enable),
        .load_use         (load_use)
    );

    assign mem_event = is_mem_op(alu_ldSt_enable) && mem_busy;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        timeout_d    = timeout_q;
        en           = 4'b1111;
        bubble_alu   = 1'b0;
        flush_decode = 1'b0;

        // Reset forces the idle RUN outputs regardless of state or inputs.
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_event) begin
                        en         = 4'b0000;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_CNT_W'(1);
                    end else if (branch_taken) begin
                        flush_decode = 1'b1;
                        bubble_alu   = 1'b1;
                        flush_cnt_d  = FLUSH_INIT_C;
                        state_d      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else if (load_use) begin
                        en         = 4'b0011;
                        bubble_alu = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Branch and load-use inputs are frozen here and ignored.
                    if (!mem_busy) begin
                        state_d = ST_RUN;
                    end else if (wait_cnt_q == MAX_WAIT_C) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        en         = 4'b0000;
                        wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (mem_event) begin
                        en         = 4'b0000;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_CNT_W'(1);
                    end else begin
                        flush_decode = 1'b1;
                        bubble_alu   = 1'b1;
                        if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                            state_d = ST_RUN;
                        end else begin
                            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        stall_d = stall_q;
        if (!en[3] && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
            stall_q     <= stall_d;
        end
    end

    assign {enable_fetch, enable_decode, enable_alu, enable_mem} = en;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance (FLUSH_CYCLES=2,
// MAX_WAIT=255) and a short one (FLUSH_CYCLES=1, MAX_WAIT=3) share inputs.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  dec_srcA_addr, dec_srcB_addr, alu_destReg_addr;
    logic        dec_useA, dec_useB, alu_we, mem_busy, branch_taken;
    logic [1:0]  alu_ldSt_enable;

    logic        ef_a, ed_a, ea_a, em_a, bub_a, fl_a, to_a;
    logic [15:0] st_a;
    logic        ef_b, ed_b, ea_b, em_b, bub_b, fl_b, to_b;
    logic [15:0] st_b;
    logic [3:0]  en_a, en_b;

    int n_cmp = 0;
    int n_bad = 0;

    assign en_a = {ef_a, ed_a, ea_a, em_a};
    assign en_b = {ef_b, ed_b, ea_b, em_b};

    always #5 clk = ~clk;

    pipeline_ctrl dut_a (
        .clk(clk), .reset(reset),
        .dec_srcA_addr(dec_srcA_addr), .dec_srcB_addr(dec_srcB_addr),
        .dec_useA(dec_useA), .dec_useB(dec_useB),
        .alu_destReg_addr(alu_destReg_addr), .alu_we(alu_we),
        .alu_ldSt_enable(alu_ldSt_enable), .mem_busy(mem_busy),
        .branch_taken(branch_taken),
        .enable_fetch(ef_a), .enable_decode(ed_a), .enable_alu(ea_a), .enable_mem(em_a),
        .bubble_alu(bub_a), .flush_decode(fl_a), .mem_timeout(to_a), .stall_cycles(st_a)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(1), .MAX_WAIT(3)) dut_b (
        .clk(clk), .reset(reset),
        .dec_srcA_addr(dec_srcA_addr), .dec_srcB_addr(dec_srcB_addr),
        .dec_useA(dec_useA), .dec_useB(dec_useB),
        .alu_destReg_addr(alu_destReg_addr), .alu_we(alu_we),
        .alu_ldSt_enable(alu_ldSt_enable), .mem_busy(mem_busy),
        .branch_taken(branch_taken),
        .enable_fetch(ef_b), .enable_decode(ed_b), .enable_alu(ea_b), .enable_mem(em_b),
        .bubble_alu(bub_b), .flush_decode(fl_b), .mem_timeout(to_b), .stall_cycles(st_b)
    );

    task automatic set_idle();
        dec_srcA_addr = 3'd0; dec_srcB_addr = 3'd0; dec_useA = 1'b0; dec_useB = 1'b0;
        alu_destReg_addr = 3'd0; alu_we = 1'b0; alu_ldSt_enable = 2'b00;
        mem_busy = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic drive_load_use_a();
        alu_ldSt_enable = 2'b01; alu_we = 1'b1; alu_destReg_addr = 3'd3;
        dec_srcA_addr = 3'd3; dec_useA = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        mem_busy = 1'b1;
        alu_ldSt_enable = 2'b01;
        branch_taken = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL rst_en_a: got %b want 1111", en_a); end
        n_cmp++; if (en_b !== 4'b1111) begin n_bad++; $display("FAIL rst_en_b: got %b want 1111", en_b); end
        n_cmp++; if ({bub_a, fl_a, to_a} !== 3'b000) begin n_bad++; $display("FAIL rst_flags_a: got %b want 000", {bub_a, fl_a, to_a}); end
        n_cmp++; if (st_a !== 16'd0) begin n_bad++; $display("FAIL rst_stall_a: got %0d want 0", st_a); end
        next_cycle();
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_load_use_a();
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b0011) begin n_bad++; $display("FAIL lu_en: got %b want 0011", en_a); end
        n_cmp++; if ({bub_a, fl_a} !== 2'b10) begin n_bad++; $display("FAIL lu_bub_fl: got %b want 10", {bub_a, fl_a}); end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL lu_release: got %b want 1111", en_a); end
        n_cmp++; if (st_a !== 16'd1) begin n_bad++; $display("FAIL lu_stall: got %0d want 1", st_a); end
        next_cycle();
        drive_load_use_a();
        dec_useA = 1'b0;
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL lu_nouse: got %b want 1111", en_a); end
        next_cycle();
        drive_load_use_a();
        dec_useA = 1'b0; dec_srcB_addr = 3'd3; dec_useB = 1'b1;
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b0011) begin n_bad++; $display("FAIL lu_srcb: got %b want 0011", en_a); end
        next_cycle();
        alu_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL lu_nowe: got %b want 1111", en_a); end
        next_cycle();
        alu_we = 1'b1; alu_ldSt_enable = 2'b10;
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL lu_store: got %b want 1111", en_a); end
        n_cmp++; if (st_a !== 16'd2) begin n_bad++; $display("FAIL lu_stall2: got %0d want 2", st_a); end
        next_cycle();
        set_idle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        alu_ldSt_enable = 2'b10;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (en_a !== 4'b0000) begin n_bad++; $display("FAIL mw_en_c%0d: got %b want 0000", i, en_a); end
            if (i == 3) begin
                n_cmp++; if (en_b !== 4'b1111) begin n_bad++; $display("FAIL mw_b_timeout_en: got %b want 1111", en_b); end
            end
            next_cycle();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL mw_resume: got %b want 1111", en_a); end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++; if (st_a !== 16'd4) begin n_bad++; $display("FAIL mw_stall_a: got %0d want 4", st_a); end
        n_cmp++; if (st_b !== 16'd3) begin n_bad++; $display("FAIL mw_stall_b: got %0d want 3", st_b); end
        n_cmp++; if (to_a !== 1'b0) begin n_bad++; $display("FAIL mw_to_a: got %b want 0", to_a); end
        n_cmp++; if (to_b !== 1'b1) begin n_bad++; $display("FAIL mw_to_b: got %b want 1", to_b); end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        alu_ldSt_enable = 2'b01;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (en_b !== 4'b0000) begin n_bad++; $display("FAIL to_wait_c%0d: got %b want 0000", i, en_b); end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (en_b !== 4'b1111) begin n_bad++; $display("FAIL to_exit_en: got %b want 1111", en_b); end
        n_cmp++; if (to_b !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", to_b); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (to_b !== 1'b1) begin n_bad++; $display("FAIL to_set: got %b want 1", to_b); end
        n_cmp++; if (en_b !== 4'b0000) begin n_bad++; $display("FAIL to_reenter: got %b want 0000", en_b); end
        next_cycle();
        set_idle();
        repeat (3) next_cycle();
        @(negedge clk);
        n_cmp++; if (to_b !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", to_b); end
        next_cycle();
        do_reset();
        @(negedge clk);
        n_cmp++; if (to_b !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", to_b); end
        next_cycle();
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1;
        @(negedge clk);
        n_cmp++; if ({fl_a, bub_a} !== 2'b11) begin n_bad++; $display("FAIL br_c0_a: got %b want 11", {fl_a, bub_a}); end
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL br_c0_en: got %b want 1111", en_a); end
        n_cmp++; if (fl_b !== 1'b1) begin n_bad++; $display("FAIL br_c0_b: got %b want 1", fl_b); end
        next_cycle();
        branch_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if ({fl_a, bub_a} !== 2'b11) begin n_bad++; $display("FAIL br_c1_a: got %b want 11", {fl_a, bub_a}); end
        n_cmp++; if (en_a !== 4'b1111) begin n_bad++; $display("FAIL br_c1_en: got %b want 1111", en_a); end
        n_cmp++; if (fl_b !== 1'b0) begin n_bad++; $display("FAIL br_c1_b: got %b want 0", fl_b); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (fl_a !== 1'b0) begin n_bad++; $display("FAIL br_c2_a: got %b want 0", fl_a); end
        n_cmp++; if (st_a !== 16'd0) begin n_bad++; $display("FAIL br_stall: got %0d want 0", st_a); end
        next_cycle();
    endtask

    task automatic test_branch_priority();
        do_reset();
        drive_load_use_a();
        branch_taken = 1'b1;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a} !== 5'b11111) begin n_bad++; $display("FAIL bp_br_wins: got %b want 11111", {en_a, fl_a}); end
        next_cycle();
        branch_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a} !== 5'b11111) begin n_bad++; $display("FAIL bp_flush_ignores_lu: got %b want 11111", {en_a, fl_a}); end
        n_cmp++; if (en_b !== 4'b0011) begin n_bad++; $display("FAIL bp_b_lu: got %b want 0011", en_b); end
        next_cycle();
        set_idle();
    endtask

    task automatic test_flush_mem();
        do_reset();
        branch_taken = 1'b1;
        next_cycle();
        branch_taken = 1'b0; alu_ldSt_enable = 2'b01; mem_busy = 1'b1;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a} !== 5'b00000) begin n_bad++; $display("FAIL fm_mem_wins: got %b want 00000", {en_a, fl_a}); end
        next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a} !== 5'b11110) begin n_bad++; $display("FAIL fm_resume: got %b want 11110", {en_a, fl_a}); end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a, bub_a} !== 6'b111100) begin n_bad++; $display("FAIL fm_discard: got %b want 111100", {en_a, fl_a, bub_a}); end
        next_cycle();
    endtask

    task automatic test_mem_branch_reset();
        do_reset();
        branch_taken = 1'b1; alu_ldSt_enable = 2'b01; mem_busy = 1'b1;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a, bub_a} !== 6'b000000) begin n_bad++; $display("FAIL mb_same: got %b want 000000", {en_a, fl_a, bub_a}); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a} !== 5'b00000) begin n_bad++; $display("FAIL mb_wait_br: got %b want 00000", {en_a, fl_a}); end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a, bub_a} !== 6'b111100) begin n_bad++; $display("FAIL mb_rst_out: got %b want 111100", {en_a, fl_a, bub_a}); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if ({st_a, to_a} !== 17'd0) begin n_bad++; $display("FAIL mb_rst_regs: got %h want 0", {st_a, to_a}); end
        next_cycle();
        reset = 1'b0; branch_taken = 1'b0; alu_ldSt_enable = 2'b00; mem_busy = 1'b1;
        @(negedge clk);
        n_cmp++; if ({en_a, fl_a} !== 5'b11110) begin n_bad++; $display("FAIL mb_after_rst: got %b want 11110", {en_a, fl_a}); end
        next_cycle();
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_branch_priority();
        test_flush_mem();
        test_mem_branch_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
